// File: rtl/seg_disp_drv.sv
// -----------------------------------------------------------------------------
// seg_disp_drv
//
// Converts an 8-bit unsigned result into three decimal digits with a
// shift-and-add-3 (double-dabble) converter, then multiplexes the digits onto
// a four-digit common-anode seven-segment display. The digit scan runs
// continuously on its own counter and only ever shows fully converted values,
// because the display registers are written in a single cycle at the end of
// each conversion.
//
// Optional feature:
//   SEG_LZB_EN  - when defined, leading zeros of the hundreds and tens digits
//                 are blanked. The ones digit and the "Err" pattern are
//                 unaffected.
//
// Parameters:
//   SCAN_DIV    - clk16M cycles per digit slot (2..65536).
//
// Ports:
//   clk16M      in   sole clock, rising edge
//   rst         in   asynchronous reset, active low
//   value[7:0]  in   unsigned result to display
//   err         in   show "Err" instead of value
//   load        in   start strobe, honoured only while busy is low
//   busy        out  conversion in progress
//   done        out  one-cycle pulse when new digits reach the display
//   seg_n[7:0]  out  active-low segments, bit0=a .. bit6=g, bit7=dp
//   dig_n[3:0]  out  active-low digit enables, bit0 = rightmost digit
// -----------------------------------------------------------------------------
module seg_disp_drv #(
   parameter int unsigned SCAN_DIV = 16384
) (
   input  logic       clk16M,
   input  logic       rst,
   input  logic [7:0] value,
   input  logic       err,
   input  logic       load,
   output logic       busy,
   output logic       done,
   output logic [7:0] seg_n,
   output logic [3:0] dig_n
);

   localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

   localparam logic [7:0] GLYPH_BLANK = 8'hFF;
   localparam logic [7:0] GLYPH_E     = 8'h86;
   localparam logic [7:0] GLYPH_R     = 8'hAF;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      COMMIT
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      bin_q, bin_d;
   logic [11:0]     bcd_q, bcd_d;
   logic [11:0]     bcd_adj;
   logic [2:0]      cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [3:0][7:0] disp_q, disp_d;
   logic [CW-1:0]   scan_q, scan_d;
   logic [1:0]      idx_q, idx_d;
   logic [7:0]      seg_q, seg_d;
   logic [3:0]      dig_q, dig_d;

   // Decimal digit to active-low segment pattern; dp is always off.
   function automatic logic [7:0] glyph(input logic [3:0] d);
      logic [7:0] g;
      case (d)
         4'd0:    g = 8'hC0;
         4'd1:    g = 8'hF9;
         4'd2:    g = 8'hA4;
         4'd3:    g = 8'hB0;
         4'd4:    g = 8'h99;
         4'd5:    g = 8'h92;
         4'd6:    g = 8'h82;
         4'd7:    g = 8'hF8;
         4'd8:    g = 8'h80;
         4'd9:    g = 8'h90;
         default: g = GLYPH_BLANK;
      endcase
      return g;
   endfunction

   // Conversion FSM next-state logic. A conversion takes one load cycle,
   // eight shift cycles and one commit cycle; load is only looked at in IDLE,
   // so strobes arriving while busy are simply dropped.
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      disp_d  = disp_q;
      done_d  = 1'b0;
      bcd_adj = bcd_q;

      case (state_q)
         IDLE: begin
            if (load) begin
               bin_d   = value;
               err_d   = err;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            // Add 3 to any BCD nibble that would overflow past 9 when doubled,
            // then shift the whole {bcd, bin} word left by one.
            for (int i = 0; i < 3; i++) begin
               if (bcd_adj[4*i +: 4] >= 4'd5) begin
                  bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
               end
            end
            {bcd_d, bin_d} = {bcd_adj[10:0], bin_q, 1'b0};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = COMMIT;
            end
         end

         COMMIT: begin
            if (err_q) begin
               disp_d[3] = GLYPH_E;
               disp_d[2] = GLYPH_R;
               disp_d[1] = GLYPH_R;
               disp_d[0] = GLYPH_BLANK;
            end else begin
               disp_d[3] = GLYPH_BLANK;
               disp_d[0] = glyph(bcd_q[3:0]);
`ifdef SEG_LZB_EN
               disp_d[2] = (bcd_q[11:8] == 4'd0) ? GLYPH_BLANK : glyph(bcd_q[11:8]);
               disp_d[1] = (bcd_q[11:4] == 8'd0) ? GLYPH_BLANK : glyph(bcd_q[7:4]);
`else
               disp_d[2] = glyph(bcd_q[11:8]);
               disp_d[1] = glyph(bcd_q[7:4]);
`endif
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // busy tracks the state being entered, so it rises on the accepting
      // edge and falls on the commit edge.
      busy_d = (state_d != IDLE);
   end

   // Free-running digit scan. The segment and enable outputs are both taken
   // from the current digit index so they always switch together.
   always_comb begin
      scan_d = scan_q;
      idx_d  = idx_q;
      if (scan_q == SCAN_LAST) begin
         scan_d = '0;
         idx_d  = idx_q + 2'd1;
      end else begin
         scan_d = scan_q + CW'(1);
      end
      seg_d = disp_q[idx_q];
      dig_d = ~(4'b0001 << idx_q);
   end

   // All state, reset asynchronously to an idle converter and a dark display.
   always_ff @(posedge clk16M or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         disp_q  <= {4{GLYPH_BLANK}};
         scan_q  <= '0;
         idx_q   <= '0;
         seg_q   <= GLYPH_BLANK;
         dig_q   <= 4'hF;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         disp_q  <= disp_d;
         scan_q  <= scan_d;
         idx_q   <= idx_d;
         seg_q   <= seg_d;
         dig_q   <= dig_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign seg_n = seg_q;
   assign dig_n = dig_q;

endmodule

// File: tb/tb_seg_disp_drv.sv
// -----------------------------------------------------------------------------
// tb_seg_disp_drv
//
// Self-checking bench for seg_disp_drv with SCAN_DIV=4. Expected display
// contents come from a decimal reference model (division/modulo plus a glyph
// table); the scan is checked by decoding the active digit enable and looking
// up the model's glyph for that digit.
// -----------------------------------------------------------------------------
module tb_seg_disp_drv;

   localparam int unsigned SCAN_DIV = 4;

   localparam logic [7:0] GLYPH [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                         8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   logic       clk16M;
   logic       rst;
   logic [7:0] value;
   logic       err;
   logic       load;
   logic       busy;
   logic       done;
   logic [7:0] seg_n;
   logic [3:0] dig_n;

   logic [7:0] expDisp [4];
   int         vectorCount;
   int         missCount;

   seg_disp_drv #(.SCAN_DIV(SCAN_DIV)) dut (
      .clk16M (clk16M),
      .rst    (rst),
      .value  (value),
      .err    (err),
      .load   (load),
      .busy   (busy),
      .done   (done),
      .seg_n  (seg_n),
      .dig_n  (dig_n)
   );

   // 100 MHz-ish simulation clock; rate is irrelevant to behaviour.
   initial begin
      clk16M = 1'b0;
      forever #5 clk16M = ~clk16M;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Reference model: what the four digits should hold after a conversion.
   task automatic modelCommit(input logic [7:0] v, input logic e);
      int h, t, o;
      h = v / 100;
      t = (v / 10) % 10;
      o = v % 10;
      if (e) begin
         expDisp[3] = 8'h86;
         expDisp[2] = 8'hAF;
         expDisp[1] = 8'hAF;
         expDisp[0] = 8'hFF;
      end else begin
         expDisp[3] = 8'hFF;
         expDisp[0] = GLYPH[o];
`ifdef SEG_LZB_EN
         expDisp[2] = (h == 0) ? 8'hFF : GLYPH[h];
         expDisp[1] = (h == 0 && t == 0) ? 8'hFF : GLYPH[t];
`else
         expDisp[2] = GLYPH[h];
         expDisp[1] = GLYPH[t];
`endif
      end
   endtask

   task automatic modelBlank();
      for (int i = 0; i < 4; i++) expDisp[i] = 8'hFF;
   endtask

   // Watch the scan for four full digit periods and compare each visible
   // digit against the model.
   task automatic checkScan();
      int         idx;
      int         prev;
      logic       orderOk;
      logic [3:0] seen;
      seen    = 4'h0;
      orderOk = 1'b1;
      prev    = -1;
      repeat (2) @(negedge clk16M);
      for (int c = 0; c < 4 * 4 * SCAN_DIV / 4; c++) begin
         @(negedge clk16M);
         case (dig_n)
            4'hE:    idx = 0;
            4'hD:    idx = 1;
            4'hB:    idx = 2;
            4'h7:    idx = 3;
            default: idx = -1;
         endcase
         checkOutput("dig_onehot", {31'd0, idx >= 0}, 32'd1);
         if (idx >= 0) begin
            checkOutput($sformatf("seg_dig%0d", idx), {24'd0, seg_n}, {24'd0, expDisp[idx]});
            seen[idx] = 1'b1;
            if (prev >= 0 && idx != prev && idx != (prev + 1) % 4) orderOk = 1'b0;
            prev = idx;
         end
      end
      checkOutput("scan_order", {31'd0, orderOk}, 32'd1);
      checkOutput("scan_all_digits", {28'd0, seen}, 32'hF);
   endtask

   // One conversion. extraAt >= 0 raises a second load strobe (value
   // extraVal) after the sample following edge k+extraAt; it must be ignored.
   task automatic applyStimulus(input logic [7:0] v, input logic e,
                                input int extraAt, input logic [7:0] extraVal);
      @(negedge clk16M);
      value = v;
      err   = e;
      load  = 1'b1;
      @(negedge clk16M);
      load  = 1'b0;
      for (int i = 0; i <= 10; i++) begin
         if (i > 0) @(negedge clk16M);
         if (i <= 8) begin
            checkOutput($sformatf("busy_k%0d", i), {31'd0, busy}, 32'd1);
            checkOutput($sformatf("done_k%0d", i), {31'd0, done}, 32'd0);
         end else if (i == 9) begin
            checkOutput("busy_k9", {31'd0, busy}, 32'd0);
            checkOutput("done_k9", {31'd0, done}, 32'd1);
         end else begin
            checkOutput("busy_k10", {31'd0, busy}, 32'd0);
            checkOutput("done_k10", {31'd0, done}, 32'd0);
         end
         if (i == extraAt) begin
            value = extraVal;
            err   = 1'b0;
            load  = 1'b1;
         end else begin
            load  = 1'b0;
         end
      end
      load = 1'b0;
      modelCommit(v, e);
      checkScan();
   endtask

   // Conversion interrupted by reset just before edge k+4.
   task automatic applyAbort(input logic [7:0] v);
      @(negedge clk16M);
      value = v;
      err   = 1'b0;
      load  = 1'b1;
      @(negedge clk16M);
      load  = 1'b0;
      repeat (3) @(negedge clk16M);
      rst = 1'b0;
      #1;
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_seg", {24'd0, seg_n}, 32'hFF);
      @(negedge clk16M);
      rst = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk16M);
         checkOutput("abort_no_done", {31'd0, done}, 32'd0);
         checkOutput("abort_idle", {31'd0, busy}, 32'd0);
      end
      modelBlank();
      checkScan();
   endtask

   // Digit enable rotation after reset release: each digit holds SCAN_DIV
   // clocks, starting with the rightmost one on the first edge.
   task automatic checkResetRelease(input int cycles);
      int expIdx;
      for (int n = 1; n <= cycles; n++) begin
         @(negedge clk16M);
         expIdx = ((n - 1) / SCAN_DIV) % 4;
         checkOutput($sformatf("rel_dig_n%0d", n), {28'd0, dig_n}, {28'd0, ~(4'b0001 << expIdx)});
         checkOutput($sformatf("rel_seg_n%0d", n), {24'd0, seg_n}, 32'hFF);
      end
   endtask

   initial begin
      logic [7:0] rv;
      logic       re;
      vectorCount = 0;
      missCount   = 0;
      rst   = 1'b0;
      value = '0;
      err   = 1'b0;
      load  = 1'b0;
      modelBlank();

      repeat (3) @(negedge clk16M);
      checkOutput("rst_seg", {24'd0, seg_n}, 32'hFF);
      checkOutput("rst_dig", {28'd0, dig_n}, 32'hF);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      rst = 1'b1;
      checkResetRelease(6);

      // Reset in the middle of a digit slot acts without waiting for a clock.
      #2;
      rst = 1'b0;
      #1;
      checkOutput("async_seg", {24'd0, seg_n}, 32'hFF);
      checkOutput("async_dig", {28'd0, dig_n}, 32'hF);
      @(negedge clk16M);
      rst = 1'b1;
      checkResetRelease(4 * SCAN_DIV);

      $display("[TB] directed conversions");
      applyStimulus(8'd255, 1'b0, -1, 8'd0);
      applyStimulus(8'd7,   1'b0, -1, 8'd0);
      applyStimulus(8'd42,  1'b1, -1, 8'd0);
      applyStimulus(8'd10,  1'b0,  2, 8'd99);
      applyStimulus(8'd0,   1'b0,  8, 8'd200);
      applyStimulus(8'd105, 1'b0, -1, 8'd0);

      $display("[TB] reset during conversion");
      applyAbort(8'd188);
      applyStimulus(8'd123, 1'b0, -1, 8'd0);

      $display("[TB] random conversions");
      for (int r = 0; r < 8; r++) begin
         rv = 8'($urandom_range(0, 255));
         re = ($urandom_range(0, 3) == 0);
         applyStimulus(rv, re, -1, 8'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
